// File: rtl/hex_display_scheduler_pkg.sv
// Shared definitions for the hex display scheduler slice.
//   - FSM state encoding
//   - blank segment codes for both output polarities
//   - maximum number of displays on the board
//   - segment polarity helper
package hex_display_scheduler_pkg;

    localparam int MAX_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK_AL = 7'h7F;
    localparam logic [6:0] SEG_BLANK_AH = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Decoder segments are active-high; board pins want them inverted.
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Request/status bundle between the board-level logic and the scheduler.
//   value_in  : 24-bit value, nibble k goes to display k
//   load      : update request
//   blank_lz  : leading-zero blanking enable
//   busy      : scan in progress
//   done      : one-cycle pulse when every digit has been refreshed
// master = requester, slave = scheduler.
interface hex_display_scheduler_if;

    logic [23:0] value_in;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic        done;

    modport master (
        output value_in, load, blank_lz,
        input  busy, done
    );

    modport slave (
        input  value_in, load, blank_lz,
        output busy, done
    );

endinterface

// File: rtl/hex_display_scheduler_decoder.sv
// hex_decoder: combinational 4-bit nibble to seven-segment decoder.
//   nibble : value 0..F
//   seg    : active-high segments, bit 0 = a ... bit 6 = g
module hex_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: time-shares one hex_decoder across up to six
// seven-segment displays. A load captures the value, then the digits are
// scanned most-significant first, one per clock, into per-display segment
// registers, with optional leading-zero blanking.
//   CLOCK_50  : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   bus       : request/status bundle (slave side)
//   HEX0..HEX5: registered segment outputs; displays >= NUM_DIGITS stay blank
module hex_display_scheduler
    import hex_display_scheduler_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    hex_display_scheduler_if.slave  bus,
    output logic [6:0]              HEX0,
    output logic [6:0]              HEX1,
    output logic [6:0]              HEX2,
    output logic [6:0]              HEX3,
    output logic [6:0]              HEX4,
    output logic [6:0]              HEX5
);

    localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? SEG_BLANK_AL : SEG_BLANK_AH;
    localparam logic [2:0] IDX_LAST  = 3'(NUM_DIGITS - 1);

    state_t      state;
    state_t      state_nxt;
    logic        capture;
    logic        scan_step;
    logic        last_digit;

    logic [23:0] shadow;
    logic        lz;
    logic        seen_nz;
    logic [2:0]  idx;
    logic [6:0]  seg_q [MAX_DIGITS];

    logic [3:0]  nibble;
    logic [6:0]  dec_seg;
    logic        blank_digit;
    logic [6:0]  seg_wr;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_digit = (idx == 3'd0);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        scan_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    capture   = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                scan_step = 1'b1;
                if (last_digit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state == ST_SCAN);
    assign bus.done = (state == ST_DONE);

    // Select the nibble currently being scanned out of the captured value.
    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (idx == 3'(k)) begin
                nibble = shadow[4*k +: 4];
            end
        end
    end

    hex_decoder u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // A zero is blanked only while no non-zero digit has been seen above it;
    // digit 0 always shows so that a zero value reads "0".
    assign blank_digit = lz && (nibble == 4'h0) && !seen_nz && (idx != 3'd0);
    assign seg_wr      = blank_digit ? SEG_BLANK : seg_polarity(dec_seg, SEG_ACTIVE_LOW);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shadow  <= '0;
            lz      <= 1'b0;
            seen_nz <= 1'b0;
            idx     <= 3'd0;
            for (int k = 0; k < MAX_DIGITS; k++) begin
                seg_q[k] <= SEG_BLANK;
            end
        end else begin
            if (capture) begin
                shadow  <= bus.value_in;
                lz      <= bus.blank_lz;
                idx     <= IDX_LAST;
                seen_nz <= 1'b0;
            end
            if (scan_step) begin
                seen_nz <= seen_nz | (nibble != 4'h0);
                if (!last_digit) begin
                    idx <= idx - 3'd1;
                end
                // Only the digit under scan changes; the others hold their
                // previous contents until their turn comes.
                for (int k = 0; k < MAX_DIGITS; k++) begin
                    if ((k < NUM_DIGITS) && (idx == 3'(k))) begin
                        seg_q[k] <= seg_wr;
                    end
                end
            end
        end
    end

    assign HEX0 = seg_q[0];
    assign HEX1 = seg_q[1];
    assign HEX2 = seg_q[2];
    assign HEX3 = seg_q[3];
    assign HEX4 = seg_q[4];
    assign HEX5 = seg_q[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: a 6-digit and a 4-digit instance, both
// active-low, checked every cycle against a value-level model, plus literal
// expectations after each directed scenario.
module tb_hex_display_scheduler;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    hex_display_scheduler_if bus6 ();
    hex_display_scheduler_if bus4 ();

    logic [23:0] val_d  [2] = '{24'h0, 24'h0};
    logic        load_d [2] = '{1'b0, 1'b0};
    logic        lz_d   [2] = '{1'b0, 1'b0};

    assign bus6.value_in = val_d[0];
    assign bus6.load     = load_d[0];
    assign bus6.blank_lz = lz_d[0];
    assign bus4.value_in = val_d[1];
    assign bus4.load     = load_d[1];
    assign bus4.blank_lz = lz_d[1];

    logic [6:0] h6_0, h6_1, h6_2, h6_3, h6_4, h6_5;
    logic [6:0] h4_0, h4_1, h4_2, h4_3, h4_4, h4_5;

    hex_display_scheduler #(.NUM_DIGITS(6), .SEG_ACTIVE_LOW(1'b1)) dut6 (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus6),
        .HEX0 (h6_0), .HEX1 (h6_1), .HEX2 (h6_2),
        .HEX3 (h6_3), .HEX4 (h6_4), .HEX5 (h6_5)
    );

    hex_display_scheduler #(.NUM_DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut4 (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus4),
        .HEX0 (h4_0), .HEX1 (h4_1), .HEX2 (h4_2),
        .HEX3 (h4_3), .HEX4 (h4_4), .HEX5 (h4_5)
    );

    logic       busy_w [2];
    logic       done_w [2];
    logic [6:0] hex_w  [2][6];

    assign busy_w[0] = bus6.busy;
    assign done_w[0] = bus6.done;
    assign busy_w[1] = bus4.busy;
    assign done_w[1] = bus4.done;
    assign hex_w[0][0] = h6_0;
    assign hex_w[0][1] = h6_1;
    assign hex_w[0][2] = h6_2;
    assign hex_w[0][3] = h6_3;
    assign hex_w[0][4] = h6_4;
    assign hex_w[0][5] = h6_5;
    assign hex_w[1][0] = h4_0;
    assign hex_w[1][1] = h4_1;
    assign hex_w[1][2] = h4_2;
    assign hex_w[1][3] = h4_3;
    assign hex_w[1][4] = h4_4;
    assign hex_w[1][5] = h4_5;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Active-low seven-segment glyphs for 0..F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int ndig(input int i);
        return (i == 0) ? 6 : 4;
    endfunction

    // Final glyph of display k: blank if blanking is on, k is not the units
    // digit, and the value formed by digits k and above is zero.
    function automatic logic [6:0] final_seg(input logic [23:0] v, input logic lzb,
                                             input int k, input int nd);
        logic [31:0] mv;
        mv = {8'h00, v} & ((32'h1 << (4 * nd)) - 32'h1);
        if (lzb && (k != 0) && ((mv >> (4 * k)) == 32'h0)) begin
            return 7'h7F;
        end
        return GLYPH[4'(mv >> (4 * k))];
    endfunction

    // Model: phase 0 = ready; phases 1..nd = one display refreshed per edge,
    // from the top digit down; phase nd+1 = completion cycle.
    int          m_phase [2] = '{0, 0};
    logic [23:0] m_val   [2] = '{24'h0, 24'h0};
    logic        m_lz    [2] = '{1'b0, 1'b0};
    logic [6:0]  m_hex   [2][6] = '{'{default: 7'h7F}, '{default: 7'h7F}};

    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                m_phase[i] <= 0;
                m_val[i]   <= 24'h0;
                m_lz[i]    <= 1'b0;
                for (int k = 0; k < 6; k++) m_hex[i][k] <= 7'h7F;
            end else if (m_phase[i] == 0) begin
                if (load_d[i]) begin
                    m_val[i]   <= val_d[i];
                    m_lz[i]    <= lz_d[i];
                    m_phase[i] <= 1;
                end
            end else if (m_phase[i] <= ndig(i)) begin
                m_hex[i][ndig(i) - m_phase[i]] <=
                    final_seg(m_val[i], m_lz[i], ndig(i) - m_phase[i], ndig(i));
                m_phase[i] <= m_phase[i] + 1;
            end else begin
                m_phase[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_busy", i), 32'(busy_w[i]),
                32'((m_phase[i] >= 1) && (m_phase[i] <= ndig(i))));
            chk($sformatf("d%0d_done", i), 32'(done_w[i]),
                32'(m_phase[i] == ndig(i) + 1));
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("d%0d_HEX%0d", i, k), 32'(hex_w[i][k]), 32'(m_hex[i][k]));
            end
        end
    end

    task automatic chk_hex(input int i, input string tag, input logic [6:0] e5,
                           input logic [6:0] e4, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] e [6];
        e = '{e0, e1, e2, e3, e4, e5};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_d%0d_HEX%0d", tag, i, k), 32'(hex_w[i][k]), 32'(e[k]));
        end
    endtask

    // Waits (bounded) for the done pulse; returns on the negedge of the done cycle.
    task automatic wait_done(input int i, output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done_w[i]) got = 1'b1;
            else begin
                if (busy_w[i]) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_load(input int i, input logic [23:0] v, input logic lzb,
                            output int nbusy, output bit got);
        @(negedge clk);
        val_d[i]  = v;
        lz_d[i]   = lzb;
        load_d[i] = 1'b1;
        @(negedge clk);
        load_d[i] = 1'b0;
        // Inputs moving after capture must not disturb the scan.
        val_d[i]  = ~v;
        lz_d[i]   = ~lzb;
        wait_done(i, nbusy, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb;
        bit  got;
        int  ndone;

        // 1. Reset
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_hex(i, "reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
            chk($sformatf("reset_d%0d_busy", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("reset_d%0d_done", i), 32'(done_w[i]), 32'd0);
        end

        // 2. Mixed value with leading-zero blanking
        run_load(0, 24'h00A05F, 1'b1, nb, got);
        chk("t2_done_seen", 32'(got), 32'd1);
        chk("t2_busy_cycles", 32'(nb), 32'd6);
        @(negedge clk);
        chk_hex(0, "t2", 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12, 7'h0E);

        // 3. Zero value, blanking on then off
        run_load(0, 24'h000000, 1'b1, nb, got);
        chk("t3a_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk_hex(0, "t3a", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        run_load(0, 24'h000000, 1'b0, nb, got);
        chk("t3b_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk_hex(0, "t3b", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

        // 5. Reset in the 4th scan cycle
        @(negedge clk);
        val_d[0]  = 24'h888888;
        lz_d[0]   = 1'b0;
        load_d[0] = 1'b1;
        @(negedge clk);
        load_d[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_pre_HEX5", 32'(hex_w[0][5]), 32'h00);
        chk("t5_pre_HEX0", 32'(hex_w[0][0]), 32'h40);
        #2;
        resetn = 1'b0;
        #1;
        chk_hex(0, "t5", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("t5_busy", 32'(busy_w[0]), 32'd0);
        chk("t5_done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_w[0]) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'd0);

        // 4. Second load during a scan is ignored
        @(negedge clk);
        val_d[0]  = 24'h888888;
        lz_d[0]   = 1'b0;
        load_d[0] = 1'b1;
        @(negedge clk);
        load_d[0] = 1'b0;
        repeat (2) @(negedge clk);
        val_d[0]  = 24'h000001;
        lz_d[0]   = 1'b1;
        load_d[0] = 1'b1;
        @(negedge clk);
        load_d[0] = 1'b0;
        wait_done(0, nb, got);
        chk("t4_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk_hex(0, "t4", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        repeat (10) @(negedge clk);
        chk("t4_no_rescan_busy", 32'(busy_w[0]), 32'd0);
        chk_hex(0, "t4_hold", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);

        // 6. Four-digit instance
        run_load(1, 24'hFF5555, 1'b0, nb, got);
        chk("t6_done_seen", 32'(got), 32'd1);
        chk("t6_busy_cycles", 32'(nb), 32'd4);
        @(negedge clk);
        chk_hex(1, "t6", 7'h7F, 7'h7F, 7'h12, 7'h12, 7'h12, 7'h12);

        // Four-digit instance with blanking across its own top digits only
        run_load(1, 24'hFF0070, 1'b1, nb, got);
        chk("t6b_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk_hex(1, "t6b", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
